// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stage indices, stall/flush vector type and divider states shared by the pipeline controller.
package pipe_ctrl_pkg;
    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;
    localparam int STAGES  = 5;

    typedef logic [STAGES-1:0] stage_vec_t;

    // an exception squashes every younger register and lets PC load the redirect
    localparam stage_vec_t FLUSH_EXC = 5'b11110;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall requests, exception redirect and divider handshake between pipeline and controller.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;
    logic        if_stallreq;
    logic        id_stallreq;
    logic        ex_div_req;
    logic        mem_stallreq;
    logic        exc_req;
    logic [31:0] exc_target;
    stage_vec_t  stall;
    stage_vec_t  flush;
    logic        flush_pc_en;
    logic [31:0] flush_pc;
    logic        div_start;
    logic        div_cancel;
    logic        div_ready;

    modport master (
        output if_stallreq, id_stallreq, ex_div_req, mem_stallreq, exc_req, exc_target,
        input  stall, flush, flush_pc_en, flush_pc, div_start, div_cancel, div_ready
    );
    modport slave (
        input  if_stallreq, id_stallreq, ex_div_req, mem_stallreq, exc_req, exc_target,
        output stall, flush, flush_pc_en, flush_pc, div_start, div_cancel, div_ready
    );
endinterface

// File: rtl/pipe_ctrl_div_seq.sv
// pipe_ctrl_div_seq: sequences the multi-cycle divider and raises the EX stall request while it runs.
module pipe_ctrl_div_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 33
) (
    input  logic clk,
    input  logic rst,
    input  logic div_req,
    input  logic exc,
    input  logic mem_hold,
    output logic div_start,
    output logic div_cancel,
    output logic div_ready,
    output logic ex_stall
);
    localparam int CW = $clog2(DIV_CYCLES);

    div_state_t    state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
            cnt   <= '0;
        end else if (exc) begin
            state <= DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: if (div_req) begin
                    state <= DIV_RUN;
                    cnt   <= CW'(DIV_CYCLES - 1);
                end
                DIV_RUN:  if (cnt == '0) state <= DIV_DONE; else cnt <= cnt - 1'b1;
                // result leaves only once EX/MEM actually captures it
                DIV_DONE: if (!mem_hold) state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

    assign div_start  = !rst && state == DIV_IDLE && div_req && !exc;
    assign div_cancel = !rst && state != DIV_IDLE && exc;
    assign div_ready  = !rst && state == DIV_DONE && !exc;
    assign ex_stall   = !rst && (div_start || state == DIV_RUN);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stage stall requests and MEM exceptions into per-register stall/flush and sequences the divider.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 33
) (
    input  logic clk,
    input  logic rst,
    pipe_ctrl_if.slave bus
);
    logic       ex_stall;
    logic [2:0] lvl;
    stage_vec_t hold;

    pipe_ctrl_div_seq #(.DIV_CYCLES(DIV_CYCLES)) u_div_seq (
        .clk        (clk),
        .rst        (rst),
        .div_req    (bus.ex_div_req),
        .exc        (bus.exc_req),
        .mem_hold   (bus.stall[STG_MEM]),
        .div_start  (bus.div_start),
        .div_cancel (bus.div_cancel),
        .div_ready  (bus.div_ready),
        .ex_stall   (ex_stall)
    );

    // lvl = number of registers held, counted from PC up to the highest requesting stage
    assign lvl = bus.mem_stallreq ? 3'd4 : ex_stall ? 3'd3 : bus.id_stallreq ? 3'd2 :
                 bus.if_stallreq ? 3'd1 : 3'd0;
    assign hold = stage_vec_t'((6'd1 << lvl) - 6'd1);

    assign bus.stall       = (rst || bus.exc_req) ? '0 : hold;
    assign bus.flush       = rst ? '0 : bus.exc_req ? FLUSH_EXC : ({hold[STAGES-2:0], 1'b0} & ~hold);
    assign bus.flush_pc_en = !rst && bus.exc_req;
    assign bus.flush_pc    = bus.flush_pc_en ? bus.exc_target : '0;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus random traffic checked every cycle against a divide-age reference model.
module tb_pipe_ctrl;
    localparam int DIV = 4;

    logic clk = 0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   age = -1;

    pipe_ctrl_if b();
    pipe_ctrl #(.DIV_CYCLES(DIV)) dut (.clk(clk), .rst(rst), .bus(b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // age: -1 no divide, 1..DIV cycles into the run, DIV+1 result waiting
    task automatic cycle(input logic r, input logic i, input logic d, input logic e,
                         input logic m, input logic x, input logic [31:0] t);
        logic [4:0] es, ef;
        logic       ex_req, st, cn, rd;
        int         top;
        @(negedge clk);
        rst = r;
        b.if_stallreq = i; b.id_stallreq = d; b.ex_div_req = e;
        b.mem_stallreq = m; b.exc_req = x; b.exc_target = t;
        #1;
        ex_req = (age < 0 && e && !x) || (age >= 1 && age <= DIV);
        top = m ? 3 : ex_req ? 2 : d ? 1 : i ? 0 : -1;
        es = '0; ef = '0;
        for (int k = 0; k <= top; k++) es[k] = 1'b1;
        if (top >= 0) ef[top+1] = 1'b1;
        st = age < 0 && e && !x;
        cn = age >= 1 && x;
        rd = age > DIV && !x;
        if (x) begin es = '0; ef = 5'b11110; end
        if (r) begin es = '0; ef = '0; st = 0; cn = 0; rd = 0; end
        check("stall", 32'(b.stall), 32'(es));
        check("flush", 32'(b.flush), 32'(ef));
        check("flush_pc_en", 32'(b.flush_pc_en), 32'(x && !r));
        check("flush_pc", b.flush_pc, (x && !r) ? t : 32'h0);
        check("div_start", 32'(b.div_start), 32'(st));
        check("div_cancel", 32'(b.div_cancel), 32'(cn));
        check("div_ready", 32'(b.div_ready), 32'(rd));
        @(posedge clk);
        if (r || x) age = -1;
        else if (age < 0) age = e ? 1 : -1;
        else if (age <= DIV) age++;
        else if (!m) age = -1;
    endtask

    initial begin
        for (int n = 0; n < 3; n++) cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        // load-use stall for one cycle
        cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        // plain divide, then divide with MEM stall during DONE
        for (int n = 0; n < 8; n++) cycle(0, 0, 0, n < 6, 0, 0, 0);
        for (int n = 0; n < 10; n++) cycle(0, 0, 0, n < 8, n == 5 || n == 6, 0, 0);
        // exception at c2 of a divide
        for (int n = 0; n < 6; n++) cycle(0, 0, 0, n < 2, 0, n == 2, 32'hBFC00380);
        // simultaneous IF/ID/MEM requests
        cycle(0, 1, 1, 0, 1, 0, 0);
        // reset at c2 of a divide
        for (int n = 0; n < 7; n++) cycle(n >= 2 && n < 4, 0, 0, n < 2, 0, 0, 0);
        for (int n = 0; n < 3000; n++)
            cycle($urandom_range(99) < 2, $urandom_range(9) < 2, $urandom_range(9) < 2,
                  $urandom_range(9) < 6, $urandom_range(9) < 3, $urandom_range(99) < 4, $urandom);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
